i2c_regif: RTL



---
 rtl/i2c_regif_pkg.sv | 24 ++
 rtl/i2c_reqfifo.sv | 59 +++++
 rtl/i2c_regif.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/i2c_regif_pkg.sv
// Shared types and constants for the I2C register-access bridge.
package i2c_regif_pkg;

  // Default first offset of the write-protected (read-only) region.
  localparam logic [7:0] RO_BASE_DEF = 8'hC0;

  // One queued register request: rw = 1 for write.
  typedef struct packed {
    logic       rw;
    logic [7:0] ofs;
    logic [7:0] wdat;
  } req_t;

  localparam int unsigned REQ_W = $bits(req_t);

  // Memory-side access sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RDWAIT,
    RDOUT
  } state_t;

endpackage

// File: rtl/i2c_reqfifo.sv
// Request queue: dual push (slot a first, then slot b) and single pop.
// o_free reports free slots including a same-cycle pop, so a full queue
// can accept a push in the cycle its head is consumed.
module i2c_reqfifo
  import i2c_regif_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push_a,
  input  logic [REQ_W-1:0]         i_dat_a,
  input  logic                     i_push_b,
  input  logic [REQ_W-1:0]         i_dat_b,
  input  logic                     i_pop,
  output logic [REQ_W-1:0]         o_head,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_free
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [REQ_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic [PW-1:0]    wptr_b;
  logic [1:0]       n_push;

  // Slot b lands right after slot a when both are pushed.
  always_comb begin
    n_push  = {1'b0, i_push_a} + {1'b0, i_push_b};
    wptr_b  = wptr + PW'(i_push_a);
    o_head  = mem[rptr];
    o_empty = (count == '0);
    o_free  = CW'(DEPTH) - count + CW'(i_pop);
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge i_clk) begin
    if (i_push_a) mem[wptr]   <= i_dat_a;
    if (i_push_b) mem[wptr_b] <= i_dat_b;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + PW'(n_push);
      rptr  <= rptr + PW'(i_pop);
      count <= count + CW'(n_push) - CW'(i_pop);
    end
  end

endmodule

// File: rtl/i2c_regif.sv
// Register-access bridge between the I2C slave engine and the shared
// register memory port: queues slave strobes, sequences memory accesses,
// returns read data as a load strobe and NAKs protected writes.
module i2c_regif
  import i2c_regif_pkg::*;
#(
  parameter logic [7:0]  RO_BASE = RO_BASE_DEF,
  parameter int unsigned QDEPTH  = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_we,
  input  logic       i_re,
  input  logic       i_r_early,
  input  logic [7:0] i_ofs,
  input  logic [7:0] i_wdat,
  output logic [7:0] o_rdat,
  output logic       o_rd_mem,
  output logic       o_fwnak,
  output logic       o_mem_req,
  output logic       o_mem_wr,
  output logic [7:0] o_mem_addr,
  output logic [7:0] o_mem_wdat,
  input  logic       i_mem_gnt,
  input  logic [7:0] i_mem_rdat,
  input  logic       i_clr,
  output logic       o_ovf,
  output logic       o_wprot,
  output logic       o_busy
);

  localparam int unsigned FW = $clog2(QDEPTH) + 1;

  state_t           state;
  state_t           state_nx;
  logic             rd_stb;
  logic             wr_prot;
  logic             wr_ok;
  logic             push_a;
  logic             push_b;
  req_t             dat_a;
  req_t             dat_b;
  req_t             wr_ent;
  req_t             rd_ent;
  logic             ovf_set;
  logic             pop;
  logic             load;
  logic             q_empty;
  logic [REQ_W-1:0] q_head;
  req_t             head;
  logic [FW-1:0]    q_free;

  assign head = req_t'(q_head);

  i2c_reqfifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_push_a (push_a),
    .i_dat_a  (dat_a),
    .i_push_b (push_b),
    .i_dat_b  (dat_b),
    .i_pop    (pop),
    .o_head   (q_head),
    .o_empty  (q_empty),
    .o_free   (q_free)
  );

  // Strobe capture: a combined write+read needs two slots; the read is the
  // one dropped when only a single slot is free.
  always_comb begin
    rd_stb  = i_re | i_r_early;
    wr_prot = i_we && (i_ofs >= RO_BASE);
    wr_ok   = i_we && !wr_prot;
    wr_ent  = '{rw: 1'b1, ofs: i_ofs, wdat: i_wdat};
    rd_ent  = '{rw: 1'b0, ofs: i_ofs, wdat: i_wdat};
    push_a  = 1'b0;
    push_b  = 1'b0;
    dat_a   = wr_ent;
    dat_b   = rd_ent;
    ovf_set = 1'b0;
    if (wr_ok && rd_stb) begin
      if (q_free >= FW'(2)) begin
        push_a = 1'b1;
        push_b = 1'b1;
      end else if (q_free == FW'(1)) begin
        push_a  = 1'b1;
        ovf_set = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (wr_ok || rd_stb) begin
      dat_a = wr_ok ? wr_ent : rd_ent;
      if (q_free != '0) push_a = 1'b1;
      else              ovf_set = 1'b1;
    end
  end

  // Sequencer next-state and decoded outputs.
  always_comb begin
    state_nx  = state;
    pop       = 1'b0;
    load      = 1'b0;
    o_mem_req = 1'b0;
    o_rd_mem  = 1'b0;
    case (state)
      IDLE: begin
        if (!q_empty) begin
          load     = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        o_mem_req = 1'b1;
        if (i_mem_gnt) begin
          pop      = 1'b1;
          state_nx = o_mem_wr ? IDLE : RDWAIT;
        end
      end
      RDWAIT: state_nx = RDOUT;
      RDOUT: begin
        o_rd_mem = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    o_busy = !q_empty || (state != IDLE);
  end

  // Sequencer state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  // Memory request fields, read data capture, NAK pulse and sticky flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_mem_wr   <= 1'b0;
      o_mem_addr <= '0;
      o_mem_wdat <= '0;
      o_rdat     <= '1;
      o_fwnak    <= 1'b0;
      o_ovf      <= 1'b0;
      o_wprot    <= 1'b0;
    end else begin
      if (load) begin
        o_mem_wr   <= head.rw;
        o_mem_addr <= head.ofs;
        o_mem_wdat <= head.wdat;
      end
      if (state == RDWAIT) o_rdat <= i_mem_rdat;
      o_fwnak <= wr_prot;
      if (ovf_set)    o_ovf <= 1'b1;
      else if (i_clr) o_ovf <= 1'b0;
      if (wr_prot)    o_wprot <= 1'b1;
      else if (i_clr) o_wprot <= 1'b0;
    end
  end

endmodule
